// File: rtl/pclk_rate_gen.sv
// pclk_rate_gen
//   PCLK / word-clock generator on the PLL bit-rate clock.
//   PCLK divides by 10/20/40/80 with 50% duty. The active ratio changes only
//   at a PCLK period boundary, so every high and low phase is full length.
//   Bit_Rate_CLK_10 is a free-running /10 symbol clock.
//   Locked reports that the active ratio has run for LOCK_CYCLES full periods.
//
// Ports
//   Bit_Rate_Clk    in   bit-rate clock, rising edge
//   Rst             in   synchronous active-high reset
//   Div_Sel[1:0]    in   requested ratio: 00 /10, 01 /20, 10 /40, 11 /80
//   Div_Load        in   strobe, captures Div_Sel as the pending ratio
//   PCLK            out  divided clock at the active ratio
//   Bit_Rate_CLK_10 out  fixed /10 clock
//   Div_Ack         out  one-cycle pulse on the edge a new ratio takes effect
//   Locked          out  ratio stable for LOCK_CYCLES full periods
//
// No FSM: control is a set of counters plus a pending-request register.
module pclk_rate_gen #(
  parameter int unsigned CNT_W       = 7,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [1:0]  DEFAULT_SEL = 2'b00
) (
  input  logic       Bit_Rate_Clk,
  input  logic       Rst,
  input  logic [1:0] Div_Sel,
  input  logic       Div_Load,
  output logic       PCLK,
  output logic       Bit_Rate_CLK_10,
  output logic       Div_Ack,
  output logic       Locked
);

  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CYCLES);

  function automatic logic [CNT_W-1:0] last_cnt(input logic [1:0] sel);
    case (sel)
      2'b00:   last_cnt = CNT_W'(9);
      2'b01:   last_cnt = CNT_W'(19);
      2'b10:   last_cnt = CNT_W'(39);
      default: last_cnt = CNT_W'(79);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_cnt(input logic [1:0] sel);
    case (sel)
      2'b00:   half_cnt = CNT_W'(5);
      2'b01:   half_cnt = CNT_W'(10);
      2'b10:   half_cnt = CNT_W'(20);
      default: half_cnt = CNT_W'(40);
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sym_q, sym_d;
  logic             pclk_q, pclk_d;
  logic             clk10_q, clk10_d;
  logic             ack_q, ack_d;
  logic             locked_q, locked_d;
  logic [7:0]       lock_cnt_q, lock_cnt_d;
  logic             started_q, started_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic             pend_q, pend_d;
  logic             wrap;

  always_comb begin
    wrap       = (cnt_q == last_cnt(sel_q));
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    sel_d      = sel_q;
    ack_d      = 1'b0;
    lock_cnt_d = lock_cnt_q;
    // The wrap right after reset starts the first period rather than ending
    // one, so it must not count towards lock.
    started_d  = started_q | wrap;

    if (wrap) begin
      if (pend_q) begin
        sel_d = pend_sel_q;
        ack_d = 1'b1;
      end
      if (pend_q && (pend_sel_q != sel_q)) begin
        lock_cnt_d = '0;
      end else if (started_q && (lock_cnt_q != LOCK_MAX)) begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end

    locked_d = (lock_cnt_d == LOCK_MAX);
    // Registered from the next count and next ratio, so a new ratio opens
    // with a full high phase on the same edge as Div_Ack.
    pclk_d   = (cnt_d < half_cnt(sel_d));

    sym_d    = (sym_q == 4'd9) ? 4'd0 : sym_q + 4'd1;
    clk10_d  = (sym_d < 4'd5);

    // A strobe on the wrap edge itself re-arms the request for the next wrap.
    pend_d     = pend_q;
    pend_sel_d = pend_sel_q;
    if (Div_Load) begin
      pend_d     = 1'b1;
      pend_sel_d = Div_Sel;
    end else if (wrap) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      cnt_q      <= last_cnt(DEFAULT_SEL);
      sym_q      <= 4'd9;
      pclk_q     <= 1'b0;
      clk10_q    <= 1'b0;
      ack_q      <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      started_q  <= 1'b0;
      sel_q      <= DEFAULT_SEL;
      pend_sel_q <= DEFAULT_SEL;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      pclk_q     <= pclk_d;
      clk10_q    <= clk10_d;
      ack_q      <= ack_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      started_q  <= started_d;
      sel_q      <= sel_d;
      pend_sel_q <= pend_sel_d;
      pend_q     <= pend_d;
    end
  end

  assign PCLK            = pclk_q;
  assign Bit_Rate_CLK_10 = clk10_q;
  assign Div_Ack         = ack_q;
  assign Locked          = locked_q;

endmodule

// File: tb/tb_pclk_rate_gen.sv
// Testbench for pclk_rate_gen. Expected per-edge output values are queued by
// each scenario task and popped/compared after the matching clock edge.
module tb_pclk_rate_gen;

  logic       clk;
  logic       Rst;
  logic [1:0] Div_Sel;
  logic       Div_Load;
  logic       PCLK, Bit_Rate_CLK_10, Div_Ack, Locked;

  int edge_n;
  int n_cmp;
  int n_err;

  typedef struct {
    int e;
    int sig;
    bit val;
  } exp_t;

  exp_t sb[$];

  pclk_rate_gen #(
    .CNT_W(7),
    .LOCK_CYCLES(16),
    .DEFAULT_SEL(2'b00)
  ) dut (
    .Bit_Rate_Clk(clk),
    .Rst(Rst),
    .Div_Sel(Div_Sel),
    .Div_Load(Div_Load),
    .PCLK(PCLK),
    .Bit_Rate_CLK_10(Bit_Rate_CLK_10),
    .Div_Ack(Div_Ack),
    .Locked(Locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge k counts the k-th rising edge sampled with Rst low.
  always @(posedge clk) edge_n <= Rst ? 0 : edge_n + 1;

  function automatic bit obs(input int sig);
    case (sig)
      0:       obs = PCLK;
      1:       obs = Bit_Rate_CLK_10;
      2:       obs = Div_Ack;
      default: obs = Locked;
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      0:       sname = "pclk";
      1:       sname = "clk10";
      2:       sname = "div_ack";
      default: sname = "locked";
    endcase
  endfunction

  // Advance to the falling edge and pop every entry due at this edge.
  task automatic tick();
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].e == edge_n) begin
        n_cmp++;
        if (obs(sb[i].sig) !== sb[i].val) begin
          n_err++;
          $display("FAIL %s edge %0d: got %b want %b", sname(sb[i].sig), edge_n,
                   obs(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (edge_n < e && guard < 5000) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (edge_n < e) begin
      n_err++;
      $display("FAIL run_to timeout: got edge %0d want %0d", edge_n, e);
    end
  endtask

  task automatic push_at(input int sig, input int e, input bit v);
    exp_t x;
    x.e = e; x.sig = sig; x.val = v;
    sb.push_back(x);
  endtask

  task automatic push_clk(input int sig, input int from, input int to,
                          input int start, input int n);
    for (int e = from; e <= to; e++) push_at(sig, e, ((e - start) % n) < (n / 2));
  endtask

  task automatic push_const(input int sig, input int from, input int to, input bit v);
    for (int e = from; e <= to; e++) push_at(sig, e, v);
  endtask

  task automatic drain_check(input string name);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL %s leftover: got %0d entries want 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Strobe so the DUT samples Div_Load = 1 on edge e.
  task automatic load_at(input int e, input logic [1:0] sel);
    run_to(e - 1);
    Div_Sel  = sel;
    Div_Load = 1'b1;
    tick();
    Div_Load = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({PCLK, Bit_Rate_CLK_10, Div_Ack, Locked} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s: got %b want 0000", name,
               {PCLK, Bit_Rate_CLK_10, Div_Ack, Locked});
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_state");
    push_clk(0, 1, 40, 1, 10);
    push_clk(1, 1, 40, 1, 10);
    push_const(2, 1, 170, 1'b0);
    push_const(3, 150, 160, 1'b0);
    push_const(3, 161, 170, 1'b1);
    run_to(170);
    drain_check("test_reset");
  endtask

  task automatic test_rate_change();
    do_reset();
    push_clk(0, 1, 30, 1, 10);
    push_clk(0, 31, 150, 31, 40);
    push_clk(1, 1, 150, 1, 10);
    push_at(2, 30, 1'b0);
    push_at(2, 31, 1'b1);
    push_at(2, 32, 1'b0);
    push_at(2, 71, 1'b0);
    push_at(3, 31, 1'b0);
    push_at(3, 161, 1'b0);
    push_at(3, 670, 1'b0);
    push_at(3, 671, 1'b1);
    push_at(3, 700, 1'b1);
    load_at(23, 2'b10);
    run_to(700);
    drain_check("test_rate_change");
  endtask

  task automatic test_last_wins();
    do_reset();
    push_clk(0, 1, 10, 1, 10);
    push_clk(0, 11, 170, 11, 80);
    push_const(2, 1, 10, 1'b0);
    push_at(2, 11, 1'b1);
    push_const(2, 12, 170, 1'b0);
    load_at(3, 2'b01);
    load_at(7, 2'b11);
    run_to(170);
    drain_check("test_last_wins");
  endtask

  task automatic test_same_ratio();
    do_reset();
    push_clk(0, 150, 200, 1, 10);
    push_const(3, 161, 200, 1'b1);
    push_at(2, 170, 1'b0);
    push_at(2, 171, 1'b1);
    push_at(2, 172, 1'b0);
    push_at(2, 181, 1'b0);
    load_at(165, 2'b00);
    run_to(200);
    drain_check("test_same_ratio");
  endtask

  task automatic test_load_on_wrap();
    do_reset();
    push_clk(0, 1, 20, 1, 10);
    push_clk(0, 21, 60, 21, 20);
    push_at(2, 11, 1'b0);
    push_at(2, 20, 1'b0);
    push_at(2, 21, 1'b1);
    push_at(2, 22, 1'b0);
    push_at(2, 41, 1'b0);
    load_at(11, 2'b01);
    run_to(60);
    drain_check("test_load_on_wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_clk(0, 11, 29, 11, 40);
    push_at(2, 11, 1'b1);
    load_at(3, 2'b10);
    load_at(20, 2'b01);
    run_to(29);
    drain_check("test_reset_mid_pre");
    Rst = 1'b1;
    tick();
    check_reset_outputs("reset_mid_state");
    tick();
    Rst = 1'b0;
    push_clk(0, 1, 60, 1, 10);
    push_clk(1, 1, 60, 1, 10);
    push_const(2, 1, 170, 1'b0);
    push_at(3, 160, 1'b0);
    push_at(3, 161, 1'b1);
    run_to(170);
    drain_check("test_reset_mid");
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    Rst      = 1'b1;
    Div_Sel  = 2'b00;
    Div_Load = 1'b0;
    test_reset();
    test_rate_change();
    test_last_wins();
    test_same_ratio();
    test_load_on_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
